// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared types and constants for the 16-lane round-robin mux scheduler.
// Optional burst mode is selected with the MUX16_SCHED_BURST_EN macro.
package mux16_sched_pkg;

  localparam int NUM_REQ   = 16;
  localparam int DATA_W    = 2;
  localparam int SEL_W     = $clog2(NUM_REQ);
  localparam int MAX_BURST = 4;
  localparam int BURST_W   = $clog2(MAX_BURST);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [NUM_REQ-1:0]        req_t;
  typedef logic [SEL_W-1:0]          sel_t;
  typedef logic [DATA_W-1:0]         data_t;
  typedef logic [NUM_REQ*DATA_W-1:0] lanes_t;

  // Returns lane idx out of the packed lane bus (lane i = [2i+1:2i]).
  function automatic data_t lane_slice(input lanes_t lanes, input sel_t idx);
    data_t r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == sel_t'(i)) r = lanes[i*DATA_W +: DATA_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/mux16_rr_scheduler_if.sv
// Requester / downstream bundle of the round-robin mux scheduler.
// master = scheduler side, slave = requesters plus downstream consumer.
interface mux16_rr_scheduler_if import mux16_sched_pkg::*; ();

  req_t   req;
  lanes_t lane_data;
  req_t   ack;
  sel_t   sel;
  data_t  out_data;
  logic   out_valid;
  logic   out_ready;
  logic   busy;

  modport master (
    input  req, lane_data, out_ready,
    output ack, sel, out_data, out_valid, busy
  );

  modport slave (
    output req, lane_data, out_ready,
    input  ack, sel, out_data, out_valid, busy
  );

endinterface

// File: rtl/mux16_rr_scheduler_rr_priority_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Rotate the request vector so ptr sits at bit 0, take the lowest set bit,
// then add ptr back (mod 16) to recover the absolute lane index.
module rr_priority_pick import mux16_sched_pkg::*; (
  input  req_t req,
  input  sel_t ptr,
  output sel_t winner,
  output logic any_req
);

  req_t rotated;
  sel_t offset;

  assign rotated = req_t'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  always_comb begin
    // NOTE: offset gets a default before the loop so no path leaves it unassigned (no latch).
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = sel_t'(i);
    end
  end

  assign winner  = ptr + offset;
  assign any_req = |req;

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing a 16-lane, 2-bit mux among 16 requesters.
// Captures the winning lane into an output register, presents it valid/ready
// and acks the winner in the handshake cycle.
// Define MUX16_SCHED_BURST_EN to let a grant hold for up to MAX_BURST transfers.
module mux16_rr_scheduler import mux16_sched_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  mux16_rr_scheduler_if.master  bus
);

  state_t state;
  sel_t   ptr;
  sel_t   sel_q;
  data_t  data_q;
  logic   valid_q;
  sel_t   winner;
  logic   any_req;
  logic   handshake;

`ifdef MUX16_SCHED_BURST_EN
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  logic [BURST_W-1:0] burst_cnt;
`endif

  rr_priority_pick u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign handshake     = valid_q & bus.out_ready;
  assign bus.ack       = handshake ? (req_t'(1) << sel_q) : '0;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state != IDLE);

  // Grant FSM, rotation pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop uses <= so all updates in this block see pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef MUX16_SCHED_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_q   <= winner;
            data_q  <= lane_slice(bus.lane_data, winner);
            valid_q <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          // Without a handshake, sel and data hold so the consumer sees stable values.
          if (bus.out_ready) begin
`ifdef MUX16_SCHED_BURST_EN
            if (bus.req[sel_q] && (burst_cnt < BURST_LAST)) begin
              data_q    <= lane_slice(bus.lane_data, sel_q);
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              valid_q   <= 1'b0;
              ptr       <= sel_q + 1'b1;
              burst_cnt <= '0;
              state     <= IDLE;
            end
`else
            valid_q <= 1'b0;
            ptr     <= sel_q + 1'b1;
            state   <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: a transaction-level model
// (search loop over requesters, grant log) is compared every cycle, and
// directed scenarios pin the model with literal grant sequences.
module tb_mux16_rr_scheduler;
  import mux16_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux16_rr_scheduler_if bus();

  mux16_rr_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: is a transfer pending, which lane, what data, rotation start.
  bit m_busy  = 1'b0;
  int m_sel   = 0;
  int m_data  = 0;
  int m_ptr   = 0;
  int m_burst = 0;
  int grant_log[$];
  int hs_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane_of(input logic [31:0] ld, input int i);
    return int'((ld >> (2 * i)) & 32'h3);
  endfunction

  task automatic mreset();
    m_busy = 1'b0; m_sel = 0; m_data = 0; m_ptr = 0; m_burst = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_update();
    int w;
    if (!rst_n) begin
      mreset();
      return;
    end
    if (!m_busy) begin
      if (bus.req != '0) begin
        w = -1;
        for (int k = 0; k < 16 && w < 0; k++)
          if (bus.req[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
        m_sel = w; m_data = lane_of(bus.lane_data, w); m_busy = 1'b1; m_burst = 0;
      end
    end else if (bus.out_ready) begin
      grant_log.push_back(m_sel);
      hs_cyc.push_back(cyc);
`ifdef MUX16_SCHED_BURST_EN
      if (bus.req[m_sel] && m_burst < MAX_BURST - 1) begin
        m_burst++;
        m_data = lane_of(bus.lane_data, m_sel);
      end else begin
        m_busy = 1'b0; m_ptr = (m_sel + 1) % 16; m_burst = 0;
      end
`else
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % 16;
`endif
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    logic [31:0] exp_ack;
    exp_ack = (m_busy && bus.out_ready) ? (32'h1 << m_sel) : 32'h0;
    check("out_valid", bus.out_valid, m_busy);
    check("busy", bus.busy, m_busy);
    check("sel", bus.sel, m_sel);
    check("out_data", bus.out_data, m_data);
    check("ack", bus.ack, exp_ack);
    check("ack_onehot", ($countones(bus.ack) <= 1), 1);
  end

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    bus.req       = 16'($urandom);
    bus.lane_data = $urandom;
    bus.out_ready = 1'($urandom);
    repeat (2) step();
    bus.req = '0;
    rst_n = 1'b1;
  endtask

  task automatic run_grants(input string name, input int n, input int budget);
    int cnt = 0;
    while (grant_log.size() < n && cnt < budget) begin
      bus.lane_data = $urandom;
      step();
      cnt++;
    end
    check({name, "_count"}, grant_log.size() >= n, 1);
  endtask

  task automatic drain();
    int cnt = 0;
    bus.req = '0;
    bus.out_ready = 1'b1;
    while (m_busy && cnt < 20) begin
      step();
      cnt++;
    end
    check("drain_idle", bus.busy, 0);
  endtask

  initial begin
    int exp_seq[$];
    bus.req = '0;
    bus.lane_data = '0;
    bus.out_ready = 1'b0;

    // 1. Reset with random inputs.
    do_reset();
    rst_n = 1'b0;
    mreset();
    bus.req = 16'hFFFF; bus.out_ready = 1'b1; bus.lane_data = $urandom;
    step();
    check("t1_sel", bus.sel, 0);
    check("t1_valid", bus.out_valid, 0);
    check("t1_ack", bus.ack, 0);
    check("t1_busy", bus.busy, 0);
    bus.req = '0;
    rst_n = 1'b1;
    step();

    // 2. Single requester, lane 0 = 2'b10.
    grant_log.delete();
    bus.lane_data = 32'h0000_0002;
    bus.out_ready = 1'b1;
    bus.req = 16'h0001;
    step();
    bus.req = '0;
    bus.lane_data = 32'hFFFF_FFFD;
    check("t2_valid", bus.out_valid, 1);
    check("t2_data", bus.out_data, 2'b10);
    check("t2_sel", bus.sel, 0);
    check("t2_ack", bus.ack, 16'h0001);
    step();
    check("t2_done", bus.out_valid, 0);
    check("t2_log", grant_log.size() == 1 && grant_log[0] == 0, 1);

    // 3. All requesting: strict rotation from lane 0.
    do_reset();
    grant_log.delete(); hs_cyc.delete(); exp_seq.delete();
`ifdef MUX16_SCHED_BURST_EN
    for (int i = 0; i < 65; i++) exp_seq.push_back((i / 4) % 16);
`else
    for (int i = 0; i < 17; i++) exp_seq.push_back(i % 16);
`endif
    bus.out_ready = 1'b1;
    bus.req = 16'hFFFF;
    run_grants("t3", exp_seq.size(), 400);
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check($sformatf("t3_grant%0d", i), grant_log[i], exp_seq[i]);
`ifndef MUX16_SCHED_BURST_EN
    for (int i = 1; i < 17 && i < hs_cyc.size(); i++)
      check($sformatf("t3_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], 2);
`endif
    drain();

    // 4. ptr=1 with req=16'h8001: lane 15 first, then wrap to lane 0.
    do_reset();
    bus.out_ready = 1'b1;
    bus.req = 16'h0001;
    step();
    bus.req = '0;
    step();
    grant_log.delete(); exp_seq.delete();
`ifdef MUX16_SCHED_BURST_EN
    exp_seq = '{15, 15, 15, 15, 0};
`else
    exp_seq = '{15, 0};
`endif
    bus.req = 16'h8001;
    run_grants("t4", exp_seq.size(), 100);
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check($sformatf("t4_grant%0d", i), grant_log[i], exp_seq[i]);
    drain();

    // 5. Back-pressure with toggling lanes, then reset mid-SEND.
    do_reset();
    bus.out_ready = 1'b0;
    bus.lane_data = 32'h0000_0100;   // lane 4 = 2'b01
    bus.req = 16'h0010;
    step();
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      bus.lane_data = ~bus.lane_data ^ 32'($urandom);
      step();
    end
    check("t5_hold_data", bus.out_data, 2'b01);
    check("t5_hold_sel", bus.sel, 4);
    check("t5_hold_ack", bus.ack, 0);
    bus.out_ready = 1'b1;
    #1;
    check("t5_ack", bus.ack, 16'h0010);
    step();
    check("t5_done", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    bus.req = 16'h0100;
    step();
    check("t5_sending", bus.out_valid, 1);
    rst_n = 1'b0;
    mreset();
    bus.out_ready = 1'b1;
    #1;
    check("t5_rst_ack", bus.ack, 0);
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_busy", bus.busy, 0);
    step();
    bus.req = '0;
    rst_n = 1'b1;
    step();

    // 6. Two requesters 2 and 5 held.
    do_reset();
    grant_log.delete(); exp_seq.delete();
`ifdef MUX16_SCHED_BURST_EN
    exp_seq = '{2, 2, 2, 2, 5};
`else
    exp_seq = '{2, 5, 2, 5};
`endif
    bus.out_ready = 1'b1;
    bus.req = 16'h0024;
    run_grants("t6", exp_seq.size(), 100);
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check($sformatf("t6_grant%0d", i), grant_log[i], exp_seq[i]);
    drain();

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      bus.lane_data = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ((n % 8) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.req = req_t'(32'h1 << $urandom_range(0, 15));
          1: bus.req = 16'($urandom);
          2: bus.req = 16'hFFFF;
          default: bus.req = '0;
        endcase
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        mreset();
        step();
        rst_n = 1'b1;
      end
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
